// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - EX branch resolver with direct-mapped BTB and 2-bit direction counters
//
// Purpose:
//   IF reads the BTB combinationally on IF_PC to steer fetch. EX resolves the
//   control instruction in flight against the prediction it carried, raises a
//   redirect on mispredict and trains the BTB at the clock edge.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   IF_PC                      fetch PC to predict
//   PredTaken, PredTarget      prediction for IF_PC (target 0 when not taken)
//   ResValid                   EX holds a live instruction
//   Cur_PC, Imm                EX instruction PC and immediate
//   Branch, JalrSel, Jump      EX control type
//   AluResult                  compare result in bit 0, or JALR target
//   PredTakenEx, PredTargetEx  prediction made for this instruction at IF
//   PC_Imm, PC_Four            computed taken target and fall-through PC
//   BrPC, PcSel                redirect target and redirect strobe
//   BrCount, MissCount         resolved-control and mispredict counters
//                              (present only when BRANCH_STATS_EN is defined)
//
// Optional feature macro: BRANCH_STATS_EN

module branch_predict_unit #(
    parameter int PC_W      = 9,
    parameter int BTB_DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] IF_PC,
    output logic            PredTaken,
    output logic [31:0]     PredTarget,
    input  logic            ResValid,
    input  logic [PC_W-1:0] Cur_PC,
    input  logic [31:0]     Imm,
    input  logic            Branch,
    input  logic            JalrSel,
    input  logic            Jump,
    input  logic [31:0]     AluResult,
    input  logic            PredTakenEx,
    input  logic [31:0]     PredTargetEx,
    output logic [31:0]     PC_Imm,
    output logic [31:0]     PC_Four,
    output logic [31:0]     BrPC,
`ifdef BRANCH_STATS_EN
    output logic            PcSel,
    output logic [31:0]     BrCount,
    output logic [31:0]     MissCount
`else
    output logic            PcSel
`endif
);

    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = PC_W - IDX_W - 2;

    logic             valid_q  [BTB_DEPTH];
    logic [TAG_W-1:0] tag_q    [BTB_DEPTH];
    logic [31:0]      target_q [BTB_DEPTH];
    logic [1:0]       ctr_q    [BTB_DEPTH];

    // Instruction alignment bits never select a BTB entry.
    logic unused_if_lsb;
    assign unused_if_lsb = ^IF_PC[1:0];

    // ---------------- Predict ----------------
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_take;

    assign f_idx = IF_PC[IDX_W+1:2];
    assign f_tag = IF_PC[PC_W-1:IDX_W+2];

    // Reset gates the read so the outputs are defined before the first
    // reset edge has cleared the table.
    assign f_take     = !reset && valid_q[f_idx] && (tag_q[f_idx] == f_tag) && ctr_q[f_idx][1];
    assign PredTaken  = f_take;
    assign PredTarget = f_take ? target_q[f_idx] : 32'd0;

    // ---------------- Resolve ----------------
    logic [31:0]      cur_pc_ext;
    logic             is_ctl;
    logic             taken;
    logic             mispredict;
    logic [IDX_W-1:0] r_idx;
    logic [TAG_W-1:0] r_tag;
    logic             r_hit;

    assign cur_pc_ext = {{(32-PC_W){1'b0}}, Cur_PC};
    assign PC_Imm     = JalrSel ? AluResult : (cur_pc_ext + Imm);
    assign PC_Four    = cur_pc_ext + 32'd4;

    assign is_ctl = Branch | JalrSel | Jump;
    assign taken  = (Branch & AluResult[0]) | JalrSel | Jump;

    assign mispredict = ResValid && ((taken != PredTakenEx) ||
                                     (taken && (PredTargetEx != PC_Imm)));

    assign PcSel = mispredict;
    assign BrPC  = mispredict ? (taken ? PC_Imm : PC_Four) : 32'd0;

    assign r_idx = Cur_PC[IDX_W+1:2];
    assign r_tag = Cur_PC[PC_W-1:IDX_W+2];
    assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);

    logic train;
    logic alias_kill;
    logic force_strong;

    assign train        = ResValid && is_ctl;
    // A non-control instruction predicted taken means another PC's entry
    // aliased onto it; drop that entry so it stops misleading fetch.
    assign alias_kill   = ResValid && !is_ctl && PredTakenEx;
    assign force_strong = Jump | JalrSel;

    // ---------------- Train ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (train) begin
            if (!r_hit) begin
                valid_q[r_idx]  <= 1'b1;
                tag_q[r_idx]    <= r_tag;
                target_q[r_idx] <= PC_Imm;
                ctr_q[r_idx]    <= force_strong ? 2'b11 : (taken ? 2'b10 : 2'b01);
            end else begin
                if (force_strong)
                    ctr_q[r_idx] <= 2'b11;
                else if (taken)
                    ctr_q[r_idx] <= (ctr_q[r_idx] == 2'b11) ? 2'b11 : ctr_q[r_idx] + 2'd1;
                else
                    ctr_q[r_idx] <= (ctr_q[r_idx] == 2'b00) ? 2'b00 : ctr_q[r_idx] - 2'd1;
                if (taken)
                    target_q[r_idx] <= PC_Imm;
            end
        end else if (alias_kill) begin
            valid_q[r_idx] <= 1'b0;
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            BrCount   <= 32'd0;
            MissCount <= 32'd0;
        end else begin
            if (train && (BrCount != 32'hFFFF_FFFF))
                BrCount <= BrCount + 32'd1;
            if (mispredict && (MissCount != 32'hFFFF_FFFF))
                MissCount <= MissCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - scoreboard bench for branch_predict_unit

module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  IF_PC;
    logic        PredTaken;
    logic [31:0] PredTarget;
    logic        ResValid;
    logic [8:0]  Cur_PC;
    logic [31:0] Imm;
    logic        Branch, JalrSel, Jump;
    logic [31:0] AluResult;
    logic        PredTakenEx;
    logic [31:0] PredTargetEx;
    logic [31:0] PC_Imm, PC_Four, BrPC;
    logic        PcSel;
`ifdef BRANCH_STATS_EN
    logic [31:0] BrCount, MissCount;
`endif

    always #5 clk = ~clk;

    branch_predict_unit #(.PC_W(9), .BTB_DEPTH(16)) dut (
        .clk(clk), .reset(reset), .IF_PC(IF_PC),
        .PredTaken(PredTaken), .PredTarget(PredTarget),
        .ResValid(ResValid), .Cur_PC(Cur_PC), .Imm(Imm),
        .Branch(Branch), .JalrSel(JalrSel), .Jump(Jump),
        .AluResult(AluResult), .PredTakenEx(PredTakenEx), .PredTargetEx(PredTargetEx),
        .PC_Imm(PC_Imm), .PC_Four(PC_Four), .BrPC(BrPC),
`ifdef BRANCH_STATS_EN
        .PcSel(PcSel), .BrCount(BrCount), .MissCount(MissCount)
`else
        .PcSel(PcSel)
`endif
    );

    localparam int S_PT = 0, S_PTG = 1, S_SEL = 2, S_BRPC = 3,
                   S_IMM = 4, S_FOUR = 5, S_BRC = 6, S_MISS = 7;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] pick(int sel);
        case (sel)
            S_PT:   return {31'd0, PredTaken};
            S_PTG:  return PredTarget;
            S_SEL:  return {31'd0, PcSel};
            S_BRPC: return BrPC;
            S_IMM:  return PC_Imm;
            S_FOUR: return PC_Four;
`ifdef BRANCH_STATS_EN
            S_BRC:  return BrCount;
            S_MISS: return MissCount;
`endif
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: outputs are presented mid-cycle; drain whatever was expected.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = q.pop_front();
            act = pick(e.sel);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_v(input string name, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = name; e.sel = sel; e.exp = v;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input logic v, input logic [8:0] pc, input logic [31:0] imm,
                      input logic br, input logic jr, input logic jm,
                      input logic [31:0] alu, input logic pte, input logic [31:0] ptg);
        ResValid = v; Cur_PC = pc; Imm = imm; Branch = br; JalrSel = jr; Jump = jm;
        AluResult = alu; PredTakenEx = pte; PredTargetEx = ptg;
    endtask

    task automatic idle();
        ex(1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic redirect(input string n, input logic sel, input logic [31:0] pc);
        expect_v({n, "_pcsel"}, S_SEL, {31'd0, sel});
        expect_v({n, "_brpc"}, S_BRPC, pc);
    endtask

    task automatic predict(input string n, input logic t, input logic [31:0] tg);
        expect_v({n, "_pt"}, S_PT, {31'd0, t});
        expect_v({n, "_ptg"}, S_PTG, tg);
    endtask

    initial begin
        reset = 1'b1; IF_PC = 9'h010; idle();
        tick();
        predict("rst", 1'b0, 32'h0);
        tick();
        // Live BEQ during reset: comb outputs react, training must not.
        ex(1'b1, 9'h010, 32'h20, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 32'h0);
        predict("rst2", 1'b0, 32'h0);
        redirect("rst_beq", 1'b1, 32'h30);
        tick();
        reset = 1'b0; idle();
        predict("post_rst", 1'b0, 32'h0);
        redirect("post_rst", 1'b0, 32'h0);
        // C1 cold BEQ taken; same-cycle read returns pre-write contents
        tick();
        ex(1'b1, 9'h010, 32'h20, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 32'h0);
        redirect("cold_beq", 1'b1, 32'h30);
        expect_v("cold_imm", S_IMM, 32'h30);
        expect_v("cold_four", S_FOUR, 32'h14);
        expect_v("no_bypass", S_PT, 32'h0);
        // C2 allocated ctr=10
        tick(); idle();
        predict("alloc", 1'b1, 32'h30);
        // C3 not-taken against taken prediction: ctr 10->01
        tick();
        ex(1'b1, 9'h010, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h30);
        redirect("nt1", 1'b1, 32'h14);
        // C4
        tick(); idle();
        predict("ctr01", 1'b0, 32'h0);
        // C5 not-taken, predicted not-taken: no redirect, ctr 01->00
        tick();
        ex(1'b1, 9'h010, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        redirect("nt2", 1'b0, 32'h0);
        // C6 taken mispredict: ctr must have saturated at 00, goes to 01
        tick();
        ex(1'b1, 9'h010, 32'h20, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 32'h0);
        expect_v("sat00_pt", S_PT, 32'h0);
        redirect("t1", 1'b1, 32'h30);
        // C7 ctr 01 -> 10
        tick();
        ex(1'b1, 9'h010, 32'h20, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 32'h0);
        expect_v("ctr01b_pt", S_PT, 32'h0);
        redirect("t2", 1'b1, 32'h30);
        // C8 correct taken prediction, ctr 10 -> 11
        tick();
        ex(1'b1, 9'h010, 32'h20, 1'b1, 1'b0, 1'b0, 32'h1, 1'b1, 32'h30);
        predict("ctr10", 1'b1, 32'h30);
        redirect("t_ok", 1'b0, 32'h0);
        // C9 right direction, wrong target
        tick();
        ex(1'b1, 9'h010, 32'h20, 1'b1, 1'b0, 1'b0, 32'h1, 1'b1, 32'h34);
        redirect("tgt_bad", 1'b1, 32'h30);
        // C10 cold JALR at 0x040 -> 0x0F0
        tick();
        ex(1'b1, 9'h040, 32'h4, 1'b0, 1'b1, 1'b0, 32'hF0, 1'b0, 32'h0);
        redirect("jalr1", 1'b1, 32'hF0);
        expect_v("jalr_imm", S_IMM, 32'hF0);
        // C11
        tick(); idle(); IF_PC = 9'h040;
        predict("jalr1", 1'b1, 32'hF0);
`ifdef BRANCH_STATS_EN
        expect_v("brcount8", S_BRC, 32'd8);
        expect_v("miss6", S_MISS, 32'd6);
`endif
        // C12 JALR retargets to 0x100
        tick();
        ex(1'b1, 9'h040, 32'h4, 1'b0, 1'b1, 1'b0, 32'h100, 1'b1, 32'hF0);
        redirect("jalr2", 1'b1, 32'h100);
        // C13
        tick(); idle();
        predict("jalr2", 1'b1, 32'h100);
        // C14 JAL at 0x080 with negative offset; evicts 0x040 (same index)
        tick();
        ex(1'b1, 9'h080, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
        redirect("jal", 1'b1, 32'h70);
        // C15
        tick(); idle();
        predict("evict", 1'b0, 32'h0);
        // C16
        tick(); IF_PC = 9'h080;
        predict("jal", 1'b1, 32'h70);
        // C17 ADD at 0x050 aliasing the 0x010 entry
        tick(); IF_PC = 9'h010;
        ex(1'b1, 9'h050, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h30);
        predict("pre_alias", 1'b1, 32'h30);
        redirect("alias", 1'b1, 32'h54);
        // C18 entry invalidated; non-control predicted not-taken is quiet
        tick();
        ex(1'b1, 9'h050, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        predict("alias_inv", 1'b0, 32'h0);
        redirect("add_quiet", 1'b0, 32'h0);
`ifdef BRANCH_STATS_EN
        expect_v("brcount10", S_BRC, 32'd10);
        expect_v("miss9", S_MISS, 32'd9);
`endif
        // C19 train BEQ at 0x010 while reset asserted
        tick();
        reset = 1'b1;
        ex(1'b1, 9'h010, 32'h20, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 32'h0);
        redirect("rst_mid", 1'b1, 32'h30);
        // C20
        tick();
        reset = 1'b0; idle();
        predict("rst_mid", 1'b0, 32'h0);
`ifdef BRANCH_STATS_EN
        expect_v("brcount_rst", S_BRC, 32'd0);
        expect_v("miss_rst", S_MISS, 32'd0);
`endif
        // C21 JAL entry also cleared
        tick(); IF_PC = 9'h080;
        predict("rst_clr", 1'b0, 32'h0);

        tick();
        for (int i = 0; i < 20 && q.size() > 0; i++) tick();
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
